// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_pkg
// Description : Shared constants and quarter-wave sine table generator for the
//               FM transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package fm_pkg;

    localparam int          LUT_ADDR_W         = 10;
    localparam int          ROM_W              = 7;
    localparam int          ROM_DEPTH          = 2 ** (LUT_ADDR_W - 2);
    localparam logic [23:0] CENTER_FCW_DEFAULT = 24'h200000;
    localparam longint      C_PI_Q30           = 64'sd3373259426;

    // Elaboration-time round(127*sin(2*pi*(m+0.5)/1024)) using a Q30 Taylor series.
    function automatic logic [ROM_W-1:0] quarter_sine(input int m);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(2 * m + 1) * C_PI_Q30) / 64'sd1024;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return ROM_W'((acc * 64'sd127 + 64'sd536870912) >>> 30);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_rom.sv
`default_nettype none
// ============================================================================
// Module      : sine_rom
// Description : 256-entry quarter-wave sine table with registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_rom
    import fm_pkg::*;
(
    input  logic                    clk,
    input  logic [LUT_ADDR_W-3:0]   i_addr,
    output logic [ROM_W-1:0]        o_data
);

    logic [ROM_DEPTH-1:0][ROM_W-1:0] w_table;

    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_table
        localparam logic [ROM_W-1:0] C_ENTRY = quarter_sine(gi);
        assign w_table[gi] = C_ENTRY;
    end

    always_ff @(posedge clk) begin
        o_data <= w_table[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/fm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : fm_modulator
// Description : NCO-based FM modulator: sample-and-hold baseband, frequency
//               word, phase accumulator and quarter-wave sine lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_modulator
    import fm_pkg::*;
#(
    parameter int                 PHASE_W    = 24,
    parameter logic [PHASE_W-1:0] CENTER_FCW = PHASE_W'(CENTER_FCW_DEFAULT),
    parameter int                 DEV_SHIFT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [11:0] din,
    input  logic              din_valid,
    output logic signed [7:0] fmout,
    output logic              fmout_valid
);

    localparam int DIN_W = 12;
    localparam int IDX_W = LUT_ADDR_W - 2;

    logic signed [DIN_W-1:0]   r_hold;
    logic [PHASE_W-1:0]        r_fcw;
    logic [PHASE_W-1:0]        r_phase;
    logic                      r_neg;
    logic [4:0]                r_valid_pipe;
    logic signed [7:0]         r_fmout;

    logic [PHASE_W-1:0]        w_dev;
    logic [LUT_ADDR_W-1:0]     w_lut_addr;
    logic [IDX_W-1:0]          w_rom_addr;
    logic [ROM_W-1:0]          w_rom_data;
    logic [7:0]                w_mag;

    assign w_dev      = {{(PHASE_W - DIN_W){r_hold[DIN_W-1]}}, r_hold} << DEV_SHIFT;
    assign w_lut_addr = r_phase[PHASE_W-1 -: LUT_ADDR_W];
    // Odd quadrants walk the quarter table backwards: 255-k is simply ~k.
    assign w_rom_addr = w_lut_addr[IDX_W] ? ~w_lut_addr[IDX_W-1:0] : w_lut_addr[IDX_W-1:0];
    assign w_mag      = {1'b0, w_rom_data};

    sine_rom u_sine_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold       <= '0;
            r_fcw        <= CENTER_FCW;
            r_phase      <= '0;
            r_neg        <= 1'b0;
            r_valid_pipe <= '0;
            r_fmout      <= '0;
        end else begin
            if (din_valid) begin
                r_hold <= din;
            end
            r_fcw        <= CENTER_FCW + w_dev;
            r_phase      <= r_phase + r_fcw;
            r_neg        <= w_lut_addr[LUT_ADDR_W-1];
            r_valid_pipe <= {r_valid_pipe[3:0], 1'b1};
            // The ROM register has no reset, so its first post-reset word is discarded.
            if (r_valid_pipe[0]) begin
                r_fmout <= r_neg ? 8'(-w_mag) : w_mag;
            end else begin
                r_fmout <= '0;
            end
        end
    end

    assign fmout       = r_fmout;
    assign fmout_valid = r_valid_pipe[4];

endmodule
`default_nettype wire

// File: tb/tb_fm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_modulator
// Description : Self-checking bench for fm_modulator with a cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_modulator;

    localparam real         C_PI  = 3.14159265358979323846;
    localparam logic [23:0] C_CTR = 24'h200000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic signed [11:0] din = '0;
    logic              din_valid = 1'b0;
    logic signed [7:0] fmout;
    logic              fmout_valid;

    always #5 clk = ~clk;

    fm_modulator dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .fmout       (fmout),
        .fmout_valid (fmout_valid)
    );

    typedef struct {
        logic [11:0] din;
        logic [23:0] fcw;
    } fcw_vec_t;

    fcw_vec_t fcw_tab[6];
    int       seq_tab[8];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] m_hold   = '0;
    logic [23:0] m_fcw    = C_CTR;
    logic [23:0] m_phase  = '0;
    int          m_run    = 0;
    int          sb_q[$];

    function automatic int ref_sample(input logic [23:0] ph);
        int q;
        int k;
        int idx;
        int mag;
        q   = int'(ph[23:22]);
        k   = int'(ph[21:14]);
        idx = (q % 2 == 1) ? 255 - k : k;
        mag = int'($floor(127.0 * $sin(2.0 * C_PI * (real'(idx) + 0.5) / 1024.0) + 0.5));
        return (q >= 2) ? -mag : mag;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic vld, input logic [11:0] d, input string tag);
        int exp_out;
        reset     = rst;
        din_valid = vld;
        din       = d;
        @(posedge clk);
        if (rst) begin
            m_hold  = '0;
            m_fcw   = C_CTR;
            m_phase = '0;
            m_run   = 0;
            sb_q.delete();
            exp_out = 0;
        end else begin
            sb_q.push_back(ref_sample(m_phase));
            exp_out = (sb_q.size() > 1) ? sb_q.pop_front() : 0;
            m_phase = m_phase + m_fcw;
            m_fcw   = 24'(32'sh200000 + $signed(m_hold) * 16);
            if (vld) m_hold = d;
            if (m_run < 5) m_run++;
        end
        #1;
        check({tag, ".fmout"}, int'(fmout), exp_out);
        check({tag, ".valid"}, int'(fmout_valid), (m_run >= 5) ? 1 : 0);
        check({tag, ".fcw"}, int'(dut.r_fcw), int'(m_fcw));
        check({tag, ".phase"}, int'(dut.r_phase), int'(m_phase));
    endtask

    task automatic carrier_from_reset(input string tag);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 12'h000, tag);
            if (i >= 1) check($sformatf("%s.seq[%0d]", tag, i), int'(fmout), seq_tab[(i - 1) % 8]);
            if (i == 3) check({tag, ".valid_e3"}, int'(fmout_valid), 0);
            if (i == 4) check({tag, ".valid_e4"}, int'(fmout_valid), 1);
        end
    endtask

    initial begin
        fcw_tab[0] = '{12'h000, 24'h200000};
        fcw_tab[1] = '{12'h7FF, 24'h207FF0};
        fcw_tab[2] = '{12'h800, 24'h1F8000};
        fcw_tab[3] = '{12'h001, 24'h200010};
        fcw_tab[4] = '{12'hFFF, 24'h1FFFF0};
        fcw_tab[5] = '{12'h400, 24'h204000};
        seq_tab    = '{0, 90, 127, 90, 0, -90, -127, -90};

        // Reset held three cycles, then a plain carrier.
        repeat (3) step(1'b1, 1'b0, 12'($urandom), "rst");
        carrier_from_reset("carrier");

        // Frequency word capture, then hold while din_valid stays low.
        foreach (fcw_tab[i]) begin
            step(1'b0, 1'b1, fcw_tab[i].din, "cap");
            step(1'b0, 1'b0, 12'($urandom), "cap1");
            check($sformatf("fcw_tab[%0d].next", i), int'(dut.r_fcw), int'(fcw_tab[i].fcw));
            repeat (3) step(1'b0, 1'b0, 12'($urandom), "hold");
            check($sformatf("fcw_tab[%0d].held", i), int'(dut.r_fcw), int'(fcw_tab[i].fcw));
        end

        // Most negative input: phase wraps repeatedly.
        step(1'b0, 1'b1, 12'h800, "neg");
        repeat (40) step(1'b0, 1'b0, 12'($urandom), "wrap");

        // One-cycle reset in the middle of modulation.
        step(1'b0, 1'b1, 12'h7FF, "mod");
        repeat (5) step(1'b0, 1'b0, 12'h000, "mod");
        step(1'b1, 1'b1, 12'h123, "midrst");
        check("midrst.fmout_zero", int'(fmout), 0);
        carrier_from_reset("restart");

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 12'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fm_modulator.md
FM_MODULATOR -- requirements
Module: fm_modulator

Interface
REQ-001 Parameter PHASE_W, default 24, phase accumulator and frequency-word width in bits.
REQ-002 Parameter CENTER_FCW, default 24'h200000, carrier frequency word (fs/8).
REQ-003 Parameter DEV_SHIFT, default 4, left shift applied to the baseband sample to form the frequency deviation.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, synchronous and active-high.
REQ-006 Port din, input, 12, signed two's-complement baseband sample.
REQ-007 Port din_valid, input, 1, din is captured only in cycles where this is high.
REQ-008 Port fmout, output, 8, signed two's-complement FM carrier sample, one per clk.
REQ-009 Port fmout_valid, output, 1, high once the pipeline holds post-reset data.

Function
REQ-010 Hold register SHALL load din on every clk edge with din_valid=1 and otherwise keep its value (sample-and-hold).
REQ-011 Frequency word SHALL be registered as fcw = CENTER_FCW + sign_extend(hold <<< DEV_SHIFT, PHASE_W), modulo 2^PHASE_W.
REQ-012 Phase accumulator SHALL update every cycle as phase <= phase + fcw, modulo 2^PHASE_W, with no saturation.
REQ-013 LUT address SHALL be phase[PHASE_W-1 -: 10]: top 2 bits are quadrant q, low 8 bits are index k.
REQ-014 Quarter-wave ROM entry m (0..255) SHALL equal round(127*sin(2*pi*(m+0.5)/1024)), unsigned 7 bits.
REQ-015 Quadrant mapping SHALL be: q0 uses ROM[k] and positive; q1 uses ROM[255-k] and positive; q2 uses ROM[k] and negated; q3 uses ROM[255-k] and negated.
REQ-016 fmout SHALL be registered; the output range is -127..+127, and -128 is never produced.
REQ-017 Latency SHALL be 4 cycles: din captured at edge n updates fcw at n+1 and phase at n+2, the ROM read completes at n+3, and fmout reflects it at n+4.
REQ-018 fmout_valid SHALL go high at the 4th edge after the edge on which reset is sampled low, and stay high until reset.
REQ-019 din_valid toggling SHALL NOT stall the phase accumulator; the carrier runs continuously.
REQ-020 din=12'h800 combined with DEV_SHIFT SHALL wrap modulo 2^PHASE_W without error or flag.

Reset
REQ-021 While reset=1, the module SHALL clear hold, phase, pipeline registers and fmout to 0, set fcw to CENTER_FCW, and drive fmout_valid to 0.
REQ-022 Reset asserted mid-stream SHALL take effect at the next edge regardless of din_valid, and in-flight samples are discarded.

Structure
REQ-023 A shared package fm_pkg SHALL hold the LUT_ADDR_W=10 and ROM_W=7 constants and the default CENTER_FCW.
REQ-024 The quarter-wave table SHALL be a separate sub-module sine_rom (8-bit address, registered 7-bit output, no reset).
REQ-025 The modulator SHALL be the transmit counterpart of the PLL demodulator path; its fmout is directly connectable to the demodulator's 8-bit input.

Verification
REQ-026 Reset held 3 cycles, then released with din=0 -> fmout=0 and fmout_valid=0 during reset; fmout_valid rises exactly 4 edges after release.
REQ-027 din=0 with default parameters -> fmout is periodic with period 8 and repeats 0,90,127,90,0,-90,-127,-90 (per REQ-014/015) once phase is aligned.
REQ-028 din=12'h7FF pulsed for 1 cycle -> fcw=24'h207FF0 from the next cycle, held after din_valid drops, and the instantaneous frequency change is visible at fmout 4 cycles after capture.
REQ-029 din=12'h800 -> fcw=24'h1F8000; phase wraps past 2^24 with no glitch (the bench checks phase continuity against a reference model).
REQ-030 Reset asserted during active modulation for 1 cycle -> all outputs are 0 the following cycle, and the sequence restarts identically to REQ-026.
REQ-031 Loopback: a 1 kHz-equivalent sine on din drives the PLL demodulator chain -> recovered dmout is correlated with the input, with correlation coefficient > 0.95 after lock.
